// File: rtl/rc_high_pass_filter_multichannel.sv
// Time-multiplexed leaky RC high-pass filter for CHANNELS audio channels.
// One shared MUL/ACC datapath walks every channel and sub-step per sample strobe.
module rc_high_pass_filter_multichannel #(
   parameter int CLOCK_RATE      = 50000000,
   parameter int SAMPLE_RATE     = 48000,
   parameter int CHANNELS        = 2,
   parameter int DATA_WIDTH      = 16,
   parameter int R               = 47000,
   parameter int C_35_SHIFTED    = 113387,
   parameter int SUBSTEP_SHIFT   = 0,
   parameter int LEAK_16_SHIFTED = 65400
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           audio_clk_en,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in,
   output logic [CHANNELS*DATA_WIDTH-1:0] out,
   output logic                           out_valid,
   output logic                           busy,
   output logic                           overrun,
   output logic                           clip
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned TW = DW + 3;
   localparam int unsigned XW = DW + 8;
   localparam int unsigned LW = DW + 18;
   localparam int unsigned PW = TW + 18;
   localparam int unsigned KW = SUBSTEP_SHIFT + 1;
   localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned S  = 1 << SUBSTEP_SHIFT;

   localparam longint DT_32    = (longint'(1) <<< 32) / (longint'(SAMPLE_RATE) * longint'(S));
   localparam longint RC_32    = (longint'(R) * longint'(C_35_SHIFTED)) >>> 3;
   localparam longint ALPHA_16 = (RC_32 <<< 16) / (RC_32 + DT_32);

   localparam logic signed [LW-1:0] LEAK_W  = LW'(LEAK_16_SHIFTED);
   localparam logic signed [PW-1:0] ALPHA_W = PW'(ALPHA_16);
   localparam logic signed [PW-1:0] Y_MAX   = PW'((longint'(1) <<< (DATA_WIDTH - 1)) - longint'(1));
   localparam logic signed [PW-1:0] Y_MIN   = PW'(-(longint'(1) <<< (DATA_WIDTH - 1)));

   // The whole schedule must fit between two sample strobes.
   if (2 * CHANNELS * (1 << SUBSTEP_SHIFT) + 2 > CLOCK_RATE / SAMPLE_RATE) begin : g_cycle_budget
      $error("rc_high_pass_filter_multichannel: schedule does not fit in one sample period");
   end

   typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

   state_t state, state_nx;

   logic signed [DW-1:0] x_new  [CHANNELS];
   logic signed [DW-1:0] x_prev [CHANNELS];
   logic signed [DW-1:0] y      [CHANNELS];
   logic [CW-1:0]        ch;
   logic [KW-1:0]        k;
   logic signed [TW-1:0] t;
   logic                 done_q;

   logic signed [DW-1:0] xn_sel, xp_sel, y_sel, y_sat;
   logic signed [XW-1:0] diff, kb, ka;
   logic signed [TW-1:0] dx, t_nx;
   logic signed [PW-1:0] acc;
   logic                 sat_hit;

   assign xn_sel = x_new[ch];
   assign xp_sel = x_prev[ch];
   assign y_sel  = y[ch];

   // x_prev cancels in xb - xa, leaving the two floored interpolation offsets.
   assign diff = XW'(xn_sel) - XW'(xp_sel);
   assign kb   = XW'($signed({1'b0, k}));
   assign ka   = kb - XW'(1);
   assign dx   = TW'(((diff * kb) >>> SUBSTEP_SHIFT) - ((diff * ka) >>> SUBSTEP_SHIFT));
   assign t_nx = TW'((LW'(y_sel) * LEAK_W) >>> 16) + dx;
   assign acc  = (PW'(t) * ALPHA_W) >>> 16;

   always_comb begin
      y_sat   = DW'(acc);
      sat_hit = 1'b0;
      if (acc > Y_MAX) begin
         y_sat   = DW'(Y_MAX);
         sat_hit = 1'b1;
      end else if (acc < Y_MIN) begin
         y_sat   = DW'(Y_MIN);
         sat_hit = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (audio_clk_en) state_nx = MUL;
         MUL:  state_nx = ACC;
         ACC:  state_nx = (k == KW'(S) && ch == CW'(CHANNELS - 1)) ? DONE : MUL;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            x_new[i]  <= '0;
            x_prev[i] <= '0;
            y[i]      <= '0;
         end
         ch        <= '0;
         k         <= '0;
         t         <= '0;
         done_q    <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         clip      <= 1'b0;
      end else begin
         done_q    <= (state == DONE);
         out_valid <= done_q;
         busy      <= (state_nx != IDLE);
         if (done_q) begin
            for (int i = 0; i < CHANNELS; i++) out[i*DW +: DW] <= y[i];
         end
         if (audio_clk_en && state != IDLE) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (audio_clk_en) begin
                  for (int i = 0; i < CHANNELS; i++) x_new[i] <= in[i*DW +: DW];
                  ch <= '0;
                  k  <= KW'(1);
               end
            end
            MUL: t <= t_nx;
            ACC: begin
               y[ch] <= y_sat;
               if (sat_hit) clip <= 1'b1;
               if (k < KW'(S)) begin
                  k <= k + KW'(1);
               end else begin
                  x_prev[ch] <= x_new[ch];
                  if (ch != CW'(CHANNELS - 1)) begin
                     ch <= ch + CW'(1);
                     k  <= KW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
